// File: rtl/systolic_array_feeder_pkg.sv
// Shared constants for the systolic array feeder, core and drain stage.
// Holds FSM encodings and width helpers for lane/counter sizing.
package systolic_pkg;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Counter width for n states; never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Skew span L = max(rows, cols) - 1.
  function automatic int lane_span(input int rows, input int cols);
    return ((rows > cols) ? rows : cols) - 1;
  endfunction

endpackage

// File: rtl/systolic_array_feeder_if.sv
// Beat input handshake and skewed lane outputs of the feeder.
// master drives beats and consumes lanes; slave is the feeder.
interface systolic_array_feeder_if
  import systolic_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2
);
  logic [ROWS*DBITS-1:0] i_A_VEC;
  logic [COLS*DBITS-1:0] i_B_VEC;
  logic                  i_VALID;
  logic                  o_READY;
  logic [ROWS*DBITS-1:0] o_A;
  logic [ROWS-1:0]       o_A_VALID;
  logic [COLS*DBITS-1:0] o_B;
  logic [COLS-1:0]       o_B_VALID;
  logic                  o_TILE_DONE;
  logic                  o_BUSY;

  modport master (
    output i_A_VEC, i_B_VEC, i_VALID,
    input  o_READY, o_A, o_A_VALID,
    input  o_B, o_B_VALID, o_TILE_DONE, o_BUSY
  );

  modport slave (
    input  i_A_VEC, i_B_VEC, i_VALID,
    output o_READY, o_A, o_A_VALID,
    output o_B, o_B_VALID, o_TILE_DONE, o_BUSY
  );
endinterface

// File: rtl/systolic_array_feeder_skew.sv
// skew_delay_line: DEPTH-stage {valid,data} register chain.
// Data entering with valid low is zeroed so bubbles carry 0.
module skew_delay_line #(
  parameter int DBITS = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DBITS-1:0] in_data,
  output logic             out_valid,
  output logic [DBITS-1:0] out_data,
  output logic             live
);
  logic [DEPTH-1:0] vld;
  logic [DBITS-1:0] dat [DEPTH];

  // Shift the chain one stage per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign live      = |vld;
endmodule

// File: rtl/systolic_array_feeder.sv
// Skews A columns / B rows into per-lane diagonal streams.
// Frames KDEPTH beats per tile and drains L cycles between tiles.
module systolic_array_feeder
  import systolic_pkg::*;
#(
  parameter int DBITS  = 8,
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int KDEPTH = 2
) (
  input logic i_CLK,
  input logic i_RST,
  systolic_array_feeder_if.slave bus
);
  localparam int L     = lane_span(ROWS, COLS);
  localparam int CNT_W = cnt_bits(KDEPTH);
  localparam int DRN_W = cnt_bits(L + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             run;
  logic             done;
  logic             ready;
  logic             accept;
  logic             last_beat;
  logic             drain_end;

  logic [DBITS-1:0]      a_dat [ROWS];
  logic [DBITS-1:0]      b_dat [COLS];
  logic [ROWS-1:0]       a_vld;
  logic [ROWS-1:0]       a_live;
  logic [COLS-1:0]       b_vld;
  logic [COLS-1:0]       b_live;
  logic [ROWS*DBITS-1:0] a_bus;
  logic [COLS*DBITS-1:0] b_bus;

  assign ready     = run & (state == ST_LOAD);
  assign accept    = bus.i_VALID & ready;
  assign last_beat = beat_cnt == CNT_W'(KDEPTH - 1);
  assign drain_end = drn_cnt == DRN_W'(L - 1);

  // Tile framing: count beats, then hold off input for L drain cycles.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= ST_LOAD;
      beat_cnt <= '0;
      drn_cnt  <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
    end else begin
      run  <= 1'b1;
      done <= 1'b0;
      unique case (1'b1)
        state == ST_LOAD: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (L > 0) state <= ST_DRAIN;
              else       done  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        state == ST_DRAIN: begin
          if (drain_end) begin
            drn_cnt <= '0;
            state   <= ST_LOAD;
            done    <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_a
    skew_delay_line #(.DBITS(DBITS), .DEPTH(r + 1)) u_dl (
      .clk      (i_CLK),
      .rst      (i_RST),
      .in_valid (accept),
      .in_data  (bus.i_A_VEC[r*DBITS +: DBITS]),
      .out_valid(a_vld[r]),
      .out_data (a_dat[r]),
      .live     (a_live[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b
    skew_delay_line #(.DBITS(DBITS), .DEPTH(c + 1)) u_dl (
      .clk      (i_CLK),
      .rst      (i_RST),
      .in_valid (accept),
      .in_data  (bus.i_B_VEC[c*DBITS +: DBITS]),
      .out_valid(b_vld[c]),
      .out_data (b_dat[c]),
      .live     (b_live[c])
    );
  end

  // Pack lane outputs back into flat buses.
  always_comb begin
    a_bus = '0;
    b_bus = '0;
    for (int r = 0; r < ROWS; r++) a_bus[r*DBITS +: DBITS] = a_dat[r];
    for (int c = 0; c < COLS; c++) b_bus[c*DBITS +: DBITS] = b_dat[c];
  end

  assign bus.o_READY     = ready;
  assign bus.o_A         = a_bus;
  assign bus.o_A_VALID   = a_vld;
  assign bus.o_B         = b_bus;
  assign bus.o_B_VALID   = b_vld;
  assign bus.o_TILE_DONE = done;
  assign bus.o_BUSY      = (beat_cnt != '0) | (state == ST_DRAIN)
                         | (|a_live) | (|b_live);
endmodule

// File: tb/tb_systolic_array_feeder.sv
// Randomized bench for three feeder configs against a schedule model.
// Configs: 2x2 K2, 4x2 K3, 1x1 K1 sharing clock and reset.
module tb_systolic_array_feeder;
  localparam int N  = 420;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_in [ND];
  logic [31:0] b_in [ND];
  logic [ND-1:0] v_in;

  logic [31:0] oa  [ND];
  logic [31:0] ob  [ND];
  logic [3:0]  oav [ND];
  logic [3:0]  obv [ND];
  logic [ND-1:0] ordy, odone, obusy;

  int checks = 0;
  int failures = 0;

  systolic_array_feeder_if #(.DBITS(8), .ROWS(2), .COLS(2)) if0 ();
  systolic_array_feeder_if #(.DBITS(8), .ROWS(4), .COLS(2)) if1 ();
  systolic_array_feeder_if #(.DBITS(8), .ROWS(1), .COLS(1)) if2 ();

  systolic_array_feeder #(.DBITS(8), .ROWS(2), .COLS(2), .KDEPTH(2))
    u_d0 (.i_CLK(clk), .i_RST(rst), .bus(if0));
  systolic_array_feeder #(.DBITS(8), .ROWS(4), .COLS(2), .KDEPTH(3))
    u_d1 (.i_CLK(clk), .i_RST(rst), .bus(if1));
  systolic_array_feeder #(.DBITS(8), .ROWS(1), .COLS(1), .KDEPTH(1))
    u_d2 (.i_CLK(clk), .i_RST(rst), .bus(if2));

  assign if0.i_A_VEC = a_in[0][15:0];
  assign if0.i_B_VEC = b_in[0][15:0];
  assign if0.i_VALID = v_in[0];
  assign if1.i_A_VEC = a_in[1];
  assign if1.i_B_VEC = b_in[1][15:0];
  assign if1.i_VALID = v_in[1];
  assign if2.i_A_VEC = a_in[2][7:0];
  assign if2.i_B_VEC = b_in[2][7:0];
  assign if2.i_VALID = v_in[2];

  assign oa[0]  = {16'b0, if0.o_A};
  assign ob[0]  = {16'b0, if0.o_B};
  assign oav[0] = {2'b0, if0.o_A_VALID};
  assign obv[0] = {2'b0, if0.o_B_VALID};
  assign oa[1]  = if1.o_A;
  assign ob[1]  = {16'b0, if1.o_B};
  assign oav[1] = if1.o_A_VALID;
  assign obv[1] = {2'b0, if1.o_B_VALID};
  assign oa[2]  = {24'b0, if2.o_A};
  assign ob[2]  = {24'b0, if2.o_B};
  assign oav[2] = {3'b0, if2.o_A_VALID};
  assign obv[2] = {3'b0, if2.o_B_VALID};
  assign ordy   = {if2.o_READY, if1.o_READY, if0.o_READY};
  assign odone  = {if2.o_TILE_DONE, if1.o_TILE_DONE, if0.o_TILE_DONE};
  assign obusy  = {if2.o_BUSY, if1.o_BUSY, if0.o_BUSY};

  function automatic int rows_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction
  function automatic int cols_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic int k_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction
  function automatic int span_of(input int d);
    int r = rows_of(d);
    int c = cols_of(d);
    return ((r > c) ? r : c) - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: accept history per cycle plus tile bookkeeping.
  bit          hv [ND][N];
  logic [31:0] ha [ND][N];
  logic [31:0] hb [ND][N];
  int cnt    [ND];
  int t_last [ND];
  int rst_last;
  bit drain_rst_done;

  function automatic bit beat_live(input int d, input int t);
    return t >= 0 && t > rst_last && hv[d][t];
  endfunction

  function automatic bit draining(input int d, input int u);
    return t_last[d] > rst_last && u > t_last[d] && u <= t_last[d] + span_of(d);
  endfunction

  initial begin
    logic [31:0] w;
    bit ev, exp_rdy[ND], acc, busy_e;
    int tt, sp;
    rst = 1'b1;
    v_in = '0;
    for (int d = 0; d < ND; d++) begin
      a_in[d] = '0;
      b_in[d] = '0;
      cnt[d] = 0;
      t_last[d] = -1000;
    end
    rst_last = -1;
    drain_rst_done = 1'b0;

    for (int u = 0; u < N; u++) begin
      for (int d = 0; d < ND; d++) begin
        sp = span_of(d);
        exp_rdy[d] = (rst_last != u - 1) && !draining(d, u) && u > 0;
        if (u == 0) continue;
        for (int r = 0; r < rows_of(d); r++) begin
          tt = u - 1 - r;
          ev = beat_live(d, tt);
          w = ev ? ha[d][tt] : 32'h0;
          chk($sformatf("d%0d c%0d av%0d", d, u, r), 32'(oav[d][r]), 32'(ev));
          chk($sformatf("d%0d c%0d a%0d", d, u, r),
              32'(oa[d][r*8 +: 8]), ev ? 32'(w[r*8 +: 8]) : 32'h0);
        end
        for (int c = 0; c < cols_of(d); c++) begin
          tt = u - 1 - c;
          ev = beat_live(d, tt);
          w = ev ? hb[d][tt] : 32'h0;
          chk($sformatf("d%0d c%0d bv%0d", d, u, c), 32'(obv[d][c]), 32'(ev));
          chk($sformatf("d%0d c%0d b%0d", d, u, c),
              32'(ob[d][c*8 +: 8]), ev ? 32'(w[c*8 +: 8]) : 32'h0);
        end
        busy_e = (cnt[d] != 0) || draining(d, u);
        for (int t = u - 1 - sp; t <= u - 1; t++)
          if (beat_live(d, t)) busy_e = 1'b1;
        chk($sformatf("d%0d c%0d rdy", d, u), 32'(ordy[d]), 32'(exp_rdy[d]));
        chk($sformatf("d%0d c%0d busy", d, u), 32'(obusy[d]), 32'(busy_e));
        chk($sformatf("d%0d c%0d done", d, u), 32'(odone[d]),
            32'(t_last[d] > rst_last && u == t_last[d] + 1 + sp));
      end

      rst = (u < 3);
      if (u > 200 && !drain_rst_done && draining(1, u)) begin
        rst = 1'b1;
        drain_rst_done = 1'b1;
      end
      if (u > 300 && $urandom_range(0, 79) == 0) rst = 1'b1;

      for (int d = 0; d < ND; d++) begin
        a_in[d] = $urandom;
        b_in[d] = $urandom;
        if (u < 60)                  v_in[d] = 1'b1;
        else if (u >= 100 && u < 130) v_in[d] = 1'b0;
        else                         v_in[d] = ($urandom_range(0, 3) != 0);
        acc = v_in[d] && exp_rdy[d] && !rst;
        hv[d][u] = acc;
        ha[d][u] = a_in[d];
        hb[d][u] = b_in[d];
        if (rst) begin
          cnt[d] = 0;
        end else if (acc) begin
          cnt[d]++;
          if (cnt[d] == k_of(d)) begin
            cnt[d] = 0;
            t_last[d] = u;
          end
        end
      end
      if (rst) rst_last = u;

      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
